// File: rtl/z80_wr_cycle_gen.sv
// Z80 memory-write bus-cycle initiator: valid/ready request in, MREQ/WR strobes and enable-muxed Lin byte out.
// Optional per-cycle enable-order checker is built when ZXV_BUSGEN_SEQCHK_EN is defined.
module z80_wr_cycle_gen #(
    parameter int unsigned WR_DELAY = 2,
    parameter int unsigned MREQ_CYC = 40,
    parameter int unsigned IDLE_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_pos,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_nowr,
    output logic        o_mreq_n,
    output logic        o_wr_n,
    input  logic        i_en_al_n,
    input  logic        i_en_ah_n,
    input  logic        i_en_d_n,
    output logic [7:0]  o_lin,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_multi,
    output logic        o_seq_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] C_WR_LAST   = 8'(WR_DELAY - 1);
    localparam logic [7:0] C_MREQ_LAST = 8'(MREQ_CYC - 1);
    localparam logic [7:0] C_IDLE_LAST = 8'(IDLE_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_mreq_n;
    logic        w_mreq_n_nxt;
    logic        r_wr_n;
    logic        w_wr_n_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_ready;
    logic        w_accept;
    logic        w_release;

    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_nowr;

    logic [7:0]  r_lin;
    logic [7:0]  w_lin_nxt;
    logic        r_err_multi;
    logic        w_multi;

    assign w_ready  = (r_state == S_IDLE) && !rst_pos;
    assign w_accept = i_valid && w_ready;
    // Last mreq-low cycle: the edge that closes this cycle raises MREQ and WR together.
    assign w_release = (r_state == S_ACTIVE) && (r_cnt == C_MREQ_LAST);

    assign o_ready     = w_ready;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_mreq_n    = r_mreq_n;
    assign o_wr_n      = r_wr_n;
    assign o_lin       = r_lin;
    assign o_err_multi = r_err_multi;

    // FSM state, phase counter and strobe registers
    always_ff @(posedge clk or posedge rst_pos) begin
        if (rst_pos) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_mreq_n <= 1'b1;
            r_wr_n   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mreq_n <= w_mreq_n_nxt;
            r_wr_n   <= w_wr_n_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // FSM next-state, counter and strobe decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mreq_n_nxt = r_mreq_n;
        w_wr_n_nxt   = r_wr_n;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = S_SETUP;
                    w_cnt_nxt    = 8'd0;
                    w_mreq_n_nxt = 1'b0;
                    w_wr_n_nxt   = 1'b1;
                end else begin
                    w_mreq_n_nxt = 1'b1;
                    w_wr_n_nxt   = 1'b1;
                end
            end
            S_SETUP: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == C_WR_LAST) begin
                    w_state_nxt = S_ACTIVE;
                    w_wr_n_nxt  = r_nowr;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_ACTIVE: begin
                if (w_release) begin
                    w_state_nxt  = S_RELEASE;
                    w_cnt_nxt    = 8'd0;
                    w_mreq_n_nxt = 1'b1;
                    w_wr_n_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == C_IDLE_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = 8'd0;
                w_mreq_n_nxt = 1'b1;
                w_wr_n_nxt   = 1'b1;
            end
        endcase
    end

    // Request latch; all-ones until the first accept so idle enables return 8'hFF
    always_ff @(posedge clk or posedge rst_pos) begin
        if (rst_pos) begin
            r_addr <= 16'hFFFF;
            r_data <= 8'hFF;
            r_nowr <= 1'b0;
        end else if (w_accept) begin
            r_addr <= i_addr;
            r_data <= i_data;
            r_nowr <= i_nowr;
        end else begin
            r_addr <= r_addr;
            r_data <= r_data;
            r_nowr <= r_nowr;
        end
    end

    // Bus mux select with priority al > ah > d, plus multi-enable detect
    always_comb begin
        w_lin_nxt = 8'hFF;
        w_multi   = 1'b0;
        if (!i_en_al_n) begin
            w_lin_nxt = r_addr[7:0];
        end else if (!i_en_ah_n) begin
            w_lin_nxt = r_addr[15:8];
        end else if (!i_en_d_n) begin
            w_lin_nxt = r_data;
        end else begin
            w_lin_nxt = 8'hFF;
        end
        if ((!i_en_al_n && !i_en_ah_n) || (!i_en_al_n && !i_en_d_n) || (!i_en_ah_n && !i_en_d_n)) begin
            w_multi = 1'b1;
        end else begin
            w_multi = 1'b0;
        end
    end

    // Registered bus byte and sticky multi-enable error
    always_ff @(posedge clk or posedge rst_pos) begin
        if (rst_pos) begin
            r_lin       <= 8'hFF;
            r_err_multi <= 1'b0;
        end else begin
            r_lin       <= w_lin_nxt;
            r_err_multi <= r_err_multi | w_multi;
        end
    end

`ifdef ZXV_BUSGEN_SEQCHK_EN
    logic r_seen_al;
    logic r_seen_ah;
    logic r_seen_d;
    logic r_seq_err;
    logic w_seq_viol;

    // Enable-order violation: out-of-order first-low, missing data phase, or enable outside MREQ
    always_comb begin
        w_seq_viol = 1'b0;
        if (r_mreq_n) begin
            if (!i_en_al_n || !i_en_ah_n || !i_en_d_n) begin
                w_seq_viol = 1'b1;
            end else begin
                w_seq_viol = 1'b0;
            end
        end else begin
            if (!i_en_al_n && !r_seen_al && (r_seen_ah || r_seen_d)) begin
                w_seq_viol = 1'b1;
            end else if (!i_en_ah_n && !r_seen_ah && !r_seen_al) begin
                w_seq_viol = 1'b1;
            end else if (!i_en_d_n && !r_seen_d && !r_seen_ah) begin
                w_seq_viol = 1'b1;
            end else if (w_release && !r_nowr && !r_seen_d && i_en_d_n) begin
                w_seq_viol = 1'b1;
            end else begin
                w_seq_viol = 1'b0;
            end
        end
    end

    // First-low tracking per mreq window, cleared on each accept
    always_ff @(posedge clk or posedge rst_pos) begin
        if (rst_pos) begin
            r_seen_al <= 1'b0;
            r_seen_ah <= 1'b0;
            r_seen_d  <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_seq_err <= r_seq_err | w_seq_viol;
            if (w_accept) begin
                r_seen_al <= 1'b0;
                r_seen_ah <= 1'b0;
                r_seen_d  <= 1'b0;
            end else if (!r_mreq_n) begin
                r_seen_al <= r_seen_al | !i_en_al_n;
                r_seen_ah <= r_seen_ah | !i_en_ah_n;
                r_seen_d  <= r_seen_d  | !i_en_d_n;
            end else begin
                r_seen_al <= r_seen_al;
                r_seen_ah <= r_seen_ah;
                r_seen_d  <= r_seen_d;
            end
        end
    end

    assign o_seq_err = r_seq_err;
`else
    assign o_seq_err = 1'b0;
`endif

endmodule
